axi4_read_master: RTL and testbench

//  Upstream AXI4 read-requester for the single-beat read slave FSM.

---
 rtl/axi4_read_master.sv | 237 +++++++++++++++++++++++
 tb/tb_axi4_read_master.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_read_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_read_master
// Purpose  : AXI4 read requester that serves a single-beat read slave.
//            Read IDs are queued from a local command port. Each queued ID is
//            issued as one AR handshake, and one R beat is collected for it.
//            The result goes out as {id, data, err} on a valid/ready response
//            port. Only one transaction is outstanding at a time, and a
//            timeout guards the R phase.
// Ports    : clk, rst_n                 clock / async active-low reset
//            cmd_valid, cmd_ready, cmd_id   command push port (FIFO)
//            arvalid, arready, arid         AXI AR channel (registered)
//            rvalid, rready, rdata          AXI R channel (rready registered)
//            rsp_valid, rsp_ready,
//            rsp_id, rsp_data, rsp_err      completion port
//            busy                           FSM active or commands queued
// Revision : 1.0 - initial release
// ============================================================================
module axi4_read_master #(
  parameter int ID_W      = 4,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16,
  parameter int RDATA_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              arvalid,
  input  logic              arready,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int c_PTR_W = $clog2(CMD_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_TMR_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [ID_W-1:0]    r_fifo_mem [CMD_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // cmd_ready is derived from the registered count alone. A pop in a full
  // cycle therefore reopens the port only on the following cycle.
  assign w_full    = (r_count == c_CNT_W'(CMD_DEPTH));
  assign w_empty   = (r_count == '0);
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= cmd_id;
    end
  end

  // --------------------------------------------------------------------------
  // Transaction FSM: state and all AXI/response outputs are registered
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_arvalid;
  logic                w_arvalid_nxt;
  logic [ID_W-1:0]     r_arid;
  logic [ID_W-1:0]     w_arid_nxt;
  logic                r_rready;
  logic                w_rready_nxt;
  logic [c_TMR_W-1:0]  r_timer;
  logic [c_TMR_W-1:0]  w_timer_nxt;
  logic                r_rsp_valid;
  logic                w_rsp_valid_nxt;
  logic [ID_W-1:0]     r_rsp_id;
  logic [ID_W-1:0]     w_rsp_id_nxt;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [DATA_W-1:0]   w_rsp_data_nxt;
  logic                r_rsp_err;
  logic                w_rsp_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_arvalid   <= 1'b0;
      r_arid      <= '0;
      r_rready    <= 1'b0;
      r_timer     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_arid      <= w_arid_nxt;
      r_rready    <= w_rready_nxt;
      r_timer     <= w_timer_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_arvalid_nxt   = r_arvalid;
    w_arid_nxt      = r_arid;
    w_rready_nxt    = r_rready;
    w_timer_nxt     = r_timer;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_pop           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_arid_nxt    = r_fifo_mem[r_rd_ptr];
          w_arvalid_nxt = 1'b1;
          w_state_nxt   = ST_ADDR;
        end
      end

      // AR must never be withdrawn once raised, so this state has no timeout.
      ST_ADDR: begin
        if (r_arvalid && arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_timer_nxt   = '0;
          w_state_nxt   = ST_DATA;
        end
      end

      // The handshake is tested before the timeout, so a beat that arrives
      // in the last allowed cycle still completes without error.
      ST_DATA: begin
        w_timer_nxt = r_timer + c_TMR_W'(1);
        if (rvalid && r_rready) begin
          w_rready_nxt = 1'b0;
          if (RDATA_LAT == 0) begin
            w_rsp_data_nxt  = rdata;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_id_nxt    = r_arid;
            w_state_nxt     = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
          w_rready_nxt    = 1'b0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_data_nxt  = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_arid;
          w_state_nxt     = ST_RESP;
        end
      end

      // The slave presents read data one cycle after the R handshake.
      ST_WAIT: begin
        w_rsp_data_nxt  = rdata;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_id_nxt    = r_arid;
        w_state_nxt     = ST_RESP;
      end

      ST_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign arvalid   = r_arvalid;
  assign arid      = r_arid;
  assign rready    = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_axi4_read_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_read_master
// Purpose  : Self-checking bench for axi4_read_master. It contains a
//            behavioural single-beat read slave whose R delay can be forced or
//            randomized, a response consumer, and a scoreboard. The expected
//            result for each command is computed from the command order, the
//            slave memory and the chosen R delay: delay >= TIMEOUT means error.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_read_master;

  localparam int ID_W    = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ID_W-1:0]   cmd_id;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  always #5 clk = ~clk;

  axi4_read_master #(
    .ID_W(ID_W), .DATA_W(DATA_W), .CMD_DEPTH(4), .TIMEOUT(TIMEOUT), .RDATA_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .arvalid(arvalid), .arready(arready), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Slave memory and control knobs
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [16];
  int  force_delay = 0;   // >= 0: fixed R delay, < 0: random
  bit  ar_rand     = 0;   // randomize arready
  int  rsp_mode    = 0;   // 0: ready, 1: random, 2: hold low

  int               ph = 0;   // 0 idle, 1 awaiting R handshake, 2 data cycle
  int               cnt = 0;
  int               cur_d = 0;
  logic [ID_W-1:0]  cur_id = '0;
  int               last_rdy_cycles = 0;

  logic [ID_W-1:0]  exp_id_q [$];
  int               delay_q  [$];
  int               rsp_count = 0;
  logic [ID_W-1:0]  last_id;
  logic [DATA_W-1:0] last_data;
  logic             last_err;
  logic [ID_W-1:0]  sb_id;
  int               sb_d;
  bit               sb_e;

  // Slave and consumer: all decisions are made on the falling edge for the
  // next rising edge, so handshakes are known before they happen.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = $urandom;
      if (!rst_n) begin
        ph = 0; arready = 1'b0; rsp_ready = 1'b0;
      end else begin
        if (ph == 2) begin
          rdata = mem[cur_id];
          ph = 0;
        end else if (ph == 1) begin
          if (!rready) begin
            ph = 0;
            last_rdy_cycles = cnt;
          end else begin
            if (cnt == cur_d) begin
              rvalid = 1'b1;
              ph = 2;
            end
            cnt++;
          end
        end
        if (arvalid) check("one_outstanding", (ph == 0), 1);
        arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ph == 0 && arvalid && arready) begin
          ph = 1; cnt = 0; cur_id = arid;
          if (force_delay >= 0) cur_d = force_delay;
          else if ($urandom_range(0, 9) < 8) cur_d = $urandom_range(0, 4);
          else cur_d = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
          delay_q.push_back(cur_d);
        end
        case (rsp_mode)
          0:       rsp_ready = 1'b1;
          1:       rsp_ready = 1'($urandom_range(0, 1));
          default: rsp_ready = 1'b0;
        endcase
        if (rsp_valid && rsp_ready) begin
          rsp_count++;
          last_id = rsp_id; last_data = rsp_data; last_err = rsp_err;
          if (exp_id_q.size() == 0 || delay_q.size() == 0) begin
            check("sb_unexpected_rsp", 1, 0);
          end else begin
            sb_id = exp_id_q.pop_front();
            sb_d  = delay_q.pop_front();
            sb_e  = (sb_d >= TIMEOUT);
            check("sb_id", rsp_id, sb_id);
            check("sb_err", rsp_err, sb_e);
            check("sb_data", rsp_data, sb_e ? '0 : mem[sb_id]);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic push(input logic [ID_W-1:0] id, output bit acc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_id    = id;
    acc       = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (acc) exp_id_q.push_back(id);
  endtask

  task automatic wait_rsp(input int n0, input int budget, input string name);
    int k = 0;
    while (rsp_count <= n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_rsp_seen"}, (rsp_count > n0), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic hold_check();
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_id", rsp_id, 4'd9);
    check("t5_rsp_data", rsp_data, 32'h0000_1009);
    check("t5_rsp_err", rsp_err, 0);
    check("t5_no_arvalid", arvalid, 0);
  endtask

  typedef struct {
    logic [ID_W-1:0]   id;
    int                delay;
    logic [ID_W-1:0]   exp_id;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    bit acc;
    int n0;
    int k;
    int pushed;

    mem[0] = 32'hAAAA_1111; mem[1] = 32'hBBBB_2222;
    mem[2] = 32'hCCCC_3333; mem[3] = 32'hDDDD_4444;
    for (int i = 4; i < 16; i++) mem[i] = 32'h0000_1000 + i;

    vecs[0] = '{4'd2,  0,  4'd2,  32'hCCCC_3333, 1'b0};
    vecs[1] = '{4'd7,  5,  4'd7,  32'h0000_1007, 1'b0};
    vecs[2] = '{4'd11, 15, 4'd11, 32'h0000_100B, 1'b0};
    vecs[3] = '{4'd12, 16, 4'd12, 32'h0000_0000, 1'b1};
    vecs[4] = '{4'd3,  1,  4'd3,  32'hDDDD_4444, 1'b0};
    vecs[5] = '{4'd0,  14, 4'd0,  32'hAAAA_1111, 1'b0};

    // T1: reset values
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0;
    #23;
    check("t1_arvalid", arvalid, 0);
    check("t1_rready", rready, 0);
    check("t1_rsp_valid", rsp_valid, 0);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_arid", arid, 0);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_data", rsp_data, 0);
    check("t1_cmd_ready", cmd_ready, 1);
    check("t1_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t1_idle_arvalid", arvalid, 0);
    end

    // T2 plus table vectors, including delays on both sides of the timeout
    for (int i = 0; i < 6; i++) begin
      force_delay = vecs[i].delay;
      n0 = rsp_count;
      push(vecs[i].id, acc);
      check("vec_accept", acc, 1);
      wait_rsp(n0, 100, "vec");
      check("vec_id", last_id, vecs[i].exp_id);
      check("vec_data", last_data, vecs[i].exp_data);
      check("vec_err", last_err, vecs[i].exp_err);
    end

    // T4: timeout with rready held exactly TIMEOUT cycles, then normal read
    force_delay = 100;
    n0 = rsp_count;
    push(4'd4, acc);
    wait_rsp(n0, 100, "t4");
    check("t4_err", last_err, 1);
    check("t4_data", last_data, 0);
    check("t4_id", last_id, 4'd4);
    check("t4_rready_cycles", last_rdy_cycles, TIMEOUT);
    force_delay = 2;
    n0 = rsp_count;
    push(4'd1, acc);
    wait_rsp(n0, 100, "t4b");
    check("t4b_err", last_err, 0);
    check("t4b_data", last_data, 32'hBBBB_2222);

    // T5 + T3: response backpressure while four commands fill the FIFO
    exp_id_q.delete(); delay_q.delete();
    force_delay = 0;
    rsp_mode = 2;
    n0 = rsp_count;
    push(4'd9, acc);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_rsp_valid_seen", rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      push(4'(i), acc);
      check("t3_accept", acc, 1);
      hold_check();
    end
    @(negedge clk);
    check("t3_full_cmd_ready", cmd_ready, 0);
    check("t3_busy", busy, 1);
    push(4'd5, acc);
    check("t3_reject_when_full", acc, 0);
    repeat (4) begin
      @(negedge clk);
      hold_check();
    end
    rsp_mode = 0;
    k = 0;
    while (rsp_count < n0 + 5 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t3_rsp_count", rsp_count - n0, 5);
    check("t3_queue_drained", exp_id_q.size(), 0);

    // T6: reset during DATA with two commands queued
    force_delay = 100;
    push(4'd5, acc);
    k = 0;
    while (!rready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_in_data", rready, 1);
    push(4'd6, acc);
    push(4'd7, acc);
    @(negedge clk);
    check("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cmd_ready", cmd_ready, 1);
    check("t6_rst_rready", rready, 0);
    check("t6_rst_arvalid", arvalid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_id_q.delete(); delay_q.delete();
    n0 = rsp_count;
    repeat (30) @(negedge clk);
    check("t6_no_rsp", rsp_count, n0);
    check("t6_busy_after", busy, 0);
    check("t6_arvalid_after", arvalid, 0);

    // Randomized traffic against the scoreboard
    exp_id_q.delete(); delay_q.delete();
    force_delay = -1; ar_rand = 1; rsp_mode = 1;
    pushed = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      k = 0;
      acc = 0;
      while (!acc && k < 200) begin
        push(4'($urandom_range(0, 15)), acc);
        k++;
      end
      if (acc) pushed++;
    end
    check("rand_all_pushed", pushed, 40);
    k = 0;
    while (exp_id_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("rand_drained", exp_id_q.size(), 0);
    check("rand_delay_q_empty", delay_q.size(), 0);
    check("rand_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
